// File: rtl/ysyx_22041412_mem_pkg.sv
// rtl/ysyx_22041412_mem_pkg.sv - shared types and helpers for the store buffer
package ysyx_22041412_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } st_size_e;

  localparam logic [63:0] RAMDISK_BASE = 64'h0000_0000_8300_0000;

  // One queued write: dword address, lane-shifted data, byte enables, region tag
  typedef struct packed {
    logic [60:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
    logic        region;
  } st_entry_t;

  localparam int ENTRY_W = $bits(st_entry_t);

  function automatic logic [7:0] size_to_mask(input logic [1:0] size);
    case (st_size_e'(size))
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Natural alignment: the low address bits inside the access size must be zero
  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
    case (st_size_e'(size))
      SZ_B:    return 1'b1;
      SZ_H:    return off[0] == 1'b0;
      SZ_W:    return off[1:0] == 2'b00;
      default: return off == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22041412_store_buf_if.sv
// rtl/ysyx_22041412_store_buf_if.sv - store, memory-write and hazard signals of the store buffer
interface ysyx_22041412_store_buf_if;
  logic        st_valid;
  logic        st_ready;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic [1:0]  st_size;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_mask;
  logic        wr_region;
  logic [63:0] ld_addr;
  logic        ld_hazard;
  logic        empty;
  logic        misalign_err;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, wr_ready, ld_addr,
    output st_ready, wr_valid, wr_addr, wr_data, wr_mask, wr_region,
           ld_hazard, empty, misalign_err
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, wr_ready, ld_addr,
    input  st_ready, wr_valid, wr_addr, wr_data, wr_mask, wr_region,
           ld_hazard, empty, misalign_err
  );
endinterface

// File: rtl/ysyx_22041412_sfifo.sv
// rtl/ysyx_22041412_sfifo.sv - generic synchronous FIFO exposing head, all entries and their valid bits
module ysyx_22041412_sfifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [W-1:0]              push_data,
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic [W-1:0]              head,
  output logic [DEPTH-1:0][W-1:0]   entries,
  output logic [DEPTH-1:0]          valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]             head_q, head_d;
  logic [PW-1:0]             tail_q, tail_d;
  logic [CW-1:0]             count_q, count_d;
  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;
  logic                      do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[head_q];
  assign entries = mem_q;
  assign valid   = valid_q;

  // Next-state: push is refused when full, pop when empty; pointers wrap naturally
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    head_d  = head_q + PW'(do_pop);
    tail_d  = tail_q + PW'(do_push);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    valid_d = valid_q;
    mem_d   = mem_q;
    if (do_pop) begin
      valid_d[head_q] = 1'b0;
    end
    if (do_push) begin
      valid_d[tail_q] = 1'b1;
      mem_d[tail_q]   = push_data;
    end
  end

  // State registers; reset discards every pending entry immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      mem_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/ysyx_22041412_store_buf.sv
// rtl/ysyx_22041412_store_buf.sv - committed-store FIFO draining as masked dword writes
module ysyx_22041412_store_buf
  import ysyx_22041412_mem_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter logic [63:0] REGION_BASE = RAMDISK_BASE
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_22041412_store_buf_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                          fifo_full, fifo_empty;
  logic [CW-1:0]                 fifo_count;
  logic [ENTRY_W-1:0]            head_raw;
  logic [DEPTH-1:0][ENTRY_W-1:0] entries_raw;
  logic [DEPTH-1:0]              entries_valid;
  st_entry_t                     push_entry;
  st_entry_t                     head;
  logic                          aligned;
  logic                          push, pop;
  logic                          hazard;
  logic                          misalign_err_q, misalign_err_d;
  logic [2:0]                    off;
  logic                          unused_ld_low;

  assign unused_ld_low = ^bus.ld_addr[2:0];

  // Store side: alignment check, lane shifting and region tag for the incoming store
  always_comb begin
    off               = bus.st_addr[2:0];
    aligned           = is_aligned(bus.st_size, off);
    push_entry.addr   = bus.st_addr[63:3];
    push_entry.data   = bus.st_data << {off, 3'b000};
    push_entry.mask   = size_to_mask(bus.st_size) << off;
    push_entry.region = (bus.st_addr >= REGION_BASE);
  end

  assign bus.st_ready = !fifo_full;
  assign push         = bus.st_valid && !fifo_full && aligned;
  assign pop          = !fifo_empty && bus.wr_ready;

  ysyx_22041412_sfifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head_raw),
    .entries   (entries_raw),
    .valid     (entries_valid)
  );

  // Write side: head entry straight from registers, zeroed when nothing is pending
  always_comb begin
    head          = st_entry_t'(head_raw);
    bus.wr_valid  = !fifo_empty;
    bus.wr_addr   = fifo_empty ? 64'd0 : {head.addr, 3'b000};
    bus.wr_data   = fifo_empty ? 64'd0 : head.data;
    bus.wr_mask   = fifo_empty ? 8'd0  : head.mask;
    bus.wr_region = fifo_empty ? 1'b0  : head.region;
  end

  // Load hazard: any valid entry in the same dword as the load; a head being drained still counts
  always_comb begin
    st_entry_t e;
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      e = st_entry_t'(entries_raw[i]);
      if (entries_valid[i] && (e.addr == bus.ld_addr[63:3])) begin
        hazard = 1'b1;
      end
    end
  end

  assign bus.ld_hazard    = hazard;
  assign bus.empty        = (fifo_count == '0);
  assign bus.misalign_err = misalign_err_q;

  // Sticky misalign flag: any presented misaligned store sets it
  always_comb begin
    misalign_err_d = misalign_err_q || (bus.st_valid && !aligned);
  end

  // Misalign flag register, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err_q <= 1'b0;
    end else begin
      misalign_err_q <= misalign_err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_store_buf.sv
// tb/tb_ysyx_22041412_store_buf.sv - scoreboard bench for the store buffer
module tb_ysyx_22041412_store_buf;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
    logic        region;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   writes_seen;
  exp_t sb[$];

  ysyx_22041412_store_buf_if bus();

  ysyx_22041412_store_buf #(
    .DEPTH       (4),
    .REGION_BASE (64'h0000_0000_8300_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented head must match the oldest expectation; pop on handshake
  always @(negedge clk) begin
    if (!rst && bus.wr_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected actual=%h/%h/%h/%b required=none",
                 bus.wr_addr, bus.wr_data, bus.wr_mask, bus.wr_region);
      end else if ({bus.wr_addr, bus.wr_data, bus.wr_mask, bus.wr_region} !== sb[0]) begin
        bad++;
        $display("FAIL wr_head actual=%h/%h/%h/%b required=%h/%h/%h/%b",
                 bus.wr_addr, bus.wr_data, bus.wr_mask, bus.wr_region,
                 sb[0].addr, sb[0].data, sb[0].mask, sb[0].region);
      end
      if (bus.wr_ready) begin
        writes_seen++;
        if (sb.size() != 0) void'(sb.pop_front());
      end
    end
  end

  task automatic do_store(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz,
                          input bit exp_push, input exp_t e);
    int n;
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_size  = sz;
    n = 0;
    while (!bus.st_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) begin
      total++;
      bad++;
      $display("FAIL st_accept_timeout actual=st_ready_low required=st_ready_high");
    end
    if (exp_push) sb.push_back(e);
    tick();
    bus.st_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (!bus.empty && n < 100) begin
      tick();
      n++;
    end
    chk(nm, 64'(sb.size()), 64'd0);
    chk({nm, "_empty"}, 64'(bus.empty), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    total = 0;
    bad = 0;
    writes_seen = 0;
    rst = 1'b1;
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.st_size  = '0;
    bus.wr_ready = 1'b0;
    bus.ld_addr  = 64'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_st_ready", 64'(bus.st_ready), 64'd1);
    chk("rst_ld_hazard", 64'(bus.ld_hazard), 64'd0);
    chk("rst_wr_addr", bus.wr_addr, 64'd0);
    chk("rst_wr_data", bus.wr_data, 64'd0);
    chk("rst_wr_mask", 64'(bus.wr_mask), 64'd0);
    chk("rst_misalign", 64'(bus.misalign_err), 64'd0);
    rst = 1'b0;
    tick();

    // Byte store into an empty buffer, one-cycle latency
    bus.wr_ready = 1'b1;
    do_store(64'h8000_0005, 64'hAB, 2'd0, 1'b1,
             '{64'h8000_0000, 64'h0000_AB00_0000_0000, 8'h20, 1'b0});
    chk("byte_latency_wr_valid", 64'(bus.wr_valid), 64'd1);
    tick();
    chk("byte_then_empty", 64'(bus.empty), 64'd1);

    // Fill to full with the memory stalled
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_store(64'h8000_0000 + 64'(8 * i), 64'hA0A0_0000_0000_0000 + 64'(i), 2'd3, 1'b1,
               '{64'h8000_0000 + 64'(8 * i), 64'hA0A0_0000_0000_0000 + 64'(i), 8'hFF, 1'b0});
    end
    chk("full_st_ready", 64'(bus.st_ready), 64'd0);
    chk("full_wr_addr", bus.wr_addr, 64'h8000_0000);
    w0 = writes_seen;
    bus.st_valid = 1'b1;
    bus.st_addr  = 64'h8000_0020;
    bus.st_data  = 64'h55;
    bus.st_size  = 2'd3;
    bus.wr_ready = 1'b1;
    tick();
    bus.wr_ready = 1'b0;
    chk("full_drain_one_write", 64'(writes_seen), 64'(w0 + 1));
    chk("full_st_ready_rises", 64'(bus.st_ready), 64'd1);
    sb.push_back('{64'h8000_0020, 64'h55, 8'hFF, 1'b0});
    tick();
    bus.st_valid = 1'b0;
    chk("fifth_accepted_full", 64'(bus.st_ready), 64'd0);
    bus.wr_ready = 1'b1;
    wait_drain("fill_drain");

    // Word store into the ramdisk region
    do_store(64'h8300_0004, 64'hDEAD_BEEF, 2'd2, 1'b1,
             '{64'h8300_0000, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b1});
    wait_drain("ramdisk_drain");

    // Misaligned half store: handshaken, dropped, sticky error
    chk("pre_misalign", 64'(bus.misalign_err), 64'd0);
    do_store(64'h8000_0003, 64'h1234, 2'd1, 1'b0, '0);
    chk("misalign_empty", 64'(bus.empty), 64'd1);
    chk("misalign_set", 64'(bus.misalign_err), 64'd1);
    do_store(64'h8000_0001, 64'h5A, 2'd0, 1'b1,
             '{64'h8000_0000, 64'h5A00, 8'h02, 1'b0});
    chk("misalign_sticky", 64'(bus.misalign_err), 64'd1);
    wait_drain("misalign_drain");
    chk("misalign_sticky2", 64'(bus.misalign_err), 64'd1);

    // Load hazard against a pending store
    bus.wr_ready = 1'b0;
    bus.ld_addr  = 64'h8000_0014;
    bus.st_valid = 1'b1;
    bus.st_addr  = 64'h8000_0010;
    bus.st_data  = 64'h77;
    bus.st_size  = 2'd0;
    #1;
    chk("hz_enqueue_ignored", 64'(bus.ld_hazard), 64'd0);
    sb.push_back('{64'h8000_0010, 64'h77, 8'h01, 1'b0});
    tick();
    bus.st_valid = 1'b0;
    chk("hz_same_dword", 64'(bus.ld_hazard), 64'd1);
    bus.ld_addr = 64'h8000_0018;
    #1;
    chk("hz_next_dword", 64'(bus.ld_hazard), 64'd0);
    bus.ld_addr  = 64'h8000_0010;
    bus.wr_ready = 1'b1;
    #1;
    chk("hz_head_draining", 64'(bus.ld_hazard), 64'd1);
    tick();
    chk("hz_after_drain", 64'(bus.ld_hazard), 64'd0);
    wait_drain("hz_drain");

    // Asynchronous reset with three entries pending
    bus.wr_ready = 1'b0;
    bus.ld_addr  = 64'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      do_store(64'h8000_0000 + 64'(i), 64'(i + 1), 2'd0, 1'b1,
               '{64'h8000_0000, 64'(i + 1) << (8 * i), 8'h01 << i, 1'b0});
    end
    chk("pre_rst_hazard", 64'(bus.ld_hazard), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wr_valid", 64'(bus.wr_valid), 64'd0);
    chk("arst_empty", 64'(bus.empty), 64'd1);
    chk("arst_st_ready", 64'(bus.st_ready), 64'd1);
    chk("arst_hazard", 64'(bus.ld_hazard), 64'd0);
    chk("arst_wr_mask", 64'(bus.wr_mask), 64'd0);
    chk("arst_misalign", 64'(bus.misalign_err), 64'd0);
    sb.delete();
    #1;
    rst = 1'b0;
    bus.wr_ready = 1'b1;
    w0 = writes_seen;
    repeat (5) tick();
    chk("arst_no_writes", 64'(writes_seen), 64'(w0));
    do_store(64'h8000_0008, 64'h1234_5678, 2'd2, 1'b1,
             '{64'h8000_0008, 64'h1234_5678, 8'h0F, 1'b0});
    wait_drain("post_rst_drain");
    chk("post_rst_one_write", 64'(writes_seen), 64'(w0 + 1));

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
